// File: rtl/pipe_ctrl.sv
// Run-control and load-use hazard sequencer for the 5-stage 16-bit pipeline.
// Owns the global exec/idle state, start/halt/single-step control and debug cycle counters.
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic [15:0]      id_ir,
    input  logic [15:0]      ex_ir,
    input  logic [15:0]      wb_ir,
    input  logic             jump,
    output logic             state,
    output logic             stall,
    output logic             bubble,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_HALT  = 5'd1;
    localparam logic [4:0] OP_LOAD  = 5'd2;
    localparam logic [4:0] OP_STORE = 5'd3;
    localparam logic [4:0] OP_ADD   = 5'd4;
    localparam logic [4:0] OP_ADDC  = 5'd5;
    localparam logic [4:0] OP_SUB   = 5'd6;
    localparam logic [4:0] OP_SUBC  = 5'd7;
    localparam logic [4:0] OP_CMP   = 5'd8;
    localparam logic [4:0] OP_AND   = 5'd9;
    localparam logic [4:0] OP_OR    = 5'd10;
    localparam logic [4:0] OP_XOR   = 5'd11;
    localparam logic [4:0] OP_SHL   = 5'd12;
    localparam logic [4:0] OP_SHR   = 5'd13;
    localparam logic [4:0] OP_CAL   = 5'd14;
    localparam logic [4:0] OP_CAR   = 5'd15;
    localparam logic [4:0] OP_ADDI  = 5'd16;
    localparam logic [4:0] OP_SUBI  = 5'd17;
    localparam logic [4:0] OP_MOVI  = 5'd18;
    localparam logic [4:0] OP_JUMP  = 5'd24;
    localparam logic [4:0] OP_JZ    = 5'd25;
    localparam logic [4:0] OP_JNZ   = 5'd26;
    localparam logic [4:0] OP_JS    = 5'd27;
    localparam logic [4:0] OP_JNS   = 5'd28;
    localparam logic [4:0] OP_JC    = 5'd29;
    localparam logic [4:0] OP_JNC   = 5'd30;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_PAUSE  = 3'd2,
        S_STEP   = 3'd3,
        S_HALTED = 3'd4
    } fsm_t;

    fsm_t fsm_q, fsm_d;
    logic start_q, step_q;
    logic start_p, step_p;
    logic wb_halt;
    logic [4:0] id_op, ex_op;
    logic use_r1, use_r2, use_r3;
    logic load_use;

    assign start_p = start & ~start_q;
    assign step_p  = step & ~step_q;
    assign wb_halt = (wb_ir[15:11] == OP_HALT);
    assign id_op   = id_ir[15:11];
    assign ex_op   = ex_ir[15:11];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q   <= S_IDLE;
            start_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            start_q <= start;
            step_q  <= step;
        end
    end

    // HALT reaching WB beats every other transition out of RUN/STEP.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE: begin
                if (start_p) fsm_d = step_mode ? S_PAUSE : S_RUN;
            end
            S_RUN: begin
                if (wb_halt)        fsm_d = S_HALTED;
                else if (step_mode) fsm_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (step_p)                       fsm_d = S_STEP;
                else if (start_p && !step_mode)   fsm_d = S_RUN;
            end
            S_STEP: begin
                fsm_d = wb_halt ? S_HALTED : S_PAUSE;
            end
            S_HALTED: begin
                if (start_p) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    assign state  = (fsm_q == S_RUN) || (fsm_q == S_STEP);
    assign halted = (fsm_q == S_HALTED);

    always_comb begin
        use_r1 = 1'b0;
        use_r2 = 1'b0;
        use_r3 = 1'b0;
        case (id_op)
            OP_JZ, OP_JNZ, OP_JS, OP_JNS, OP_JC, OP_JNC,
            OP_ADDI, OP_SUBI, OP_MOVI:                     use_r1 = 1'b1;
            OP_STORE: begin
                use_r1 = 1'b1;
                use_r2 = 1'b1;
            end
            OP_LOAD, OP_SHL, OP_SHR, OP_CAL, OP_CAR:       use_r2 = 1'b1;
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP,
            OP_AND, OP_OR, OP_XOR: begin
                use_r2 = 1'b1;
                use_r3 = 1'b1;
            end
            default: ;
        endcase
    end

    // Only a LOAD one stage ahead needs a stall; one stage later, MEM forwarding covers it.
    always_comb begin
        load_use = 1'b0;
        if (ex_op == OP_LOAD && id_op != OP_JUMP) begin
            load_use = (use_r1 && id_ir[10:8] == ex_ir[10:8]) ||
                       (use_r2 && id_ir[6:4]  == ex_ir[10:8]) ||
                       (use_r3 && id_ir[2:0]  == ex_ir[10:8]);
        end
    end

    // A taken jump flushes ID/IF anyway, so spending a stall cycle would be wasted.
    assign stall  = state & load_use & ~jump;
    assign bubble = stall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (state && cycle_cnt != {CNT_W{1'b1}}) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (stall && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    logic unused_ok;
    assign unused_ok = (id_op == OP_NOP) & (ex_op == OP_NOP);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random stimulus, checked every cycle against a
// behavioural model; a second instance with 4-bit counters exercises saturation.
module tb_pipe_ctrl;

    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_HALT  = 5'd1;
    localparam logic [4:0] OP_LOAD  = 5'd2;
    localparam logic [4:0] OP_STORE = 5'd3;
    localparam logic [4:0] OP_ADD   = 5'd4;
    localparam logic [4:0] OP_ADDI  = 5'd16;
    localparam logic [4:0] OP_JUMP  = 5'd24;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_STEP = 3, M_HALTED = 4;

    logic clock, reset, start, step_mode, step, jump;
    logic [15:0] id_ir, ex_ir, wb_ir;
    logic state, stall, bubble, halted;
    logic [15:0] cycle_cnt, stall_cnt;
    logic s_state, s_stall, s_bubble, s_halted;
    logic [3:0] s_cycle_cnt, s_stall_cnt;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    pipe_ctrl #(.CNT_W(16)) dut (
        .clock(clock), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
        .id_ir(id_ir), .ex_ir(ex_ir), .wb_ir(wb_ir), .jump(jump),
        .state(state), .stall(stall), .bubble(bubble), .halted(halted),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dut_small (
        .clock(clock), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
        .id_ir(id_ir), .ex_ir(ex_ir), .wb_ir(wb_ir), .jump(jump),
        .state(s_state), .stall(s_stall), .bubble(s_bubble), .halted(s_halted),
        .cycle_cnt(s_cycle_cnt), .stall_cnt(s_stall_cnt)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [15:0] mk(input logic [4:0] op, input int a, input int b, input int c);
        logic [15:0] ir;
        ir = {op, a[2:0], 1'b0, b[2:0], 1'b0, c[2:0]};
        return ir;
    endfunction

    // Does the instruction read register r through any of its source fields?
    function automatic bit reads_reg(input logic [15:0] ir, input logic [2:0] r);
        logic [4:0] op;
        bit f1, f2, f3;
        op = ir[15:11];
        f1 = op inside {5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd16, 5'd17, 5'd18, 5'd3};
        f2 = op inside {5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                        5'd12, 5'd13, 5'd14, 5'd15};
        f3 = op inside {5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11};
        return (f1 && ir[10:8] == r) || (f2 && ir[6:4] == r) || (f3 && ir[2:0] == r);
    endfunction

    function automatic int sat(input int v, input int w);
        int top;
        top = (1 << w) - 1;
        return (v > top) ? top : v;
    endfunction

    // behavioural model
    int m_mode = M_IDLE;
    bit m_start_prev = 0, m_step_prev = 0;
    int m_cycles = 0, m_stalls = 0;

    always @(negedge clock) begin
        bit exec, hz, sp, tp, halt_wb;
        if (chk_en) begin
            if (reset) begin
                m_mode = M_IDLE; m_start_prev = 0; m_step_prev = 0;
                m_cycles = 0; m_stalls = 0;
            end
            exec = (m_mode == M_RUN) || (m_mode == M_STEP);
            hz = exec && !jump && ex_ir[15:11] == OP_LOAD && id_ir[15:11] != OP_JUMP &&
                 reads_reg(id_ir, ex_ir[10:8]);
            check("state", state, exec);
            check("stall", stall, hz);
            check("bubble", bubble, hz);
            check("halted", halted, m_mode == M_HALTED);
            check("cycle_cnt", cycle_cnt, sat(m_cycles, 16));
            check("stall_cnt", stall_cnt, sat(m_stalls, 16));
            check("small_cycle_cnt", s_cycle_cnt, sat(m_cycles, 4));
            check("small_stall_cnt", s_stall_cnt, sat(m_stalls, 4));
            if (!reset) begin
                sp = start && !m_start_prev;
                tp = step && !m_step_prev;
                halt_wb = (wb_ir[15:11] == OP_HALT);
                if (exec) m_cycles++;
                if (hz) m_stalls++;
                case (m_mode)
                    M_IDLE:   if (sp) m_mode = step_mode ? M_PAUSE : M_RUN;
                    M_RUN:    if (halt_wb) m_mode = M_HALTED; else if (step_mode) m_mode = M_PAUSE;
                    M_PAUSE:  if (tp) m_mode = M_STEP; else if (sp && !step_mode) m_mode = M_RUN;
                    M_STEP:   m_mode = halt_wb ? M_HALTED : M_PAUSE;
                    default:  if (sp) m_mode = M_IDLE;
                endcase
                m_start_prev = start;
                m_step_prev = step;
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 0; step = 0; step_mode = 0; jump = 0;
        id_ir = '0; ex_ir = '0; wb_ir = '0;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 0; step = 0; step_mode = 0; jump = 0;
        id_ir = '0; ex_ir = '0; wb_ir = '0;
        chk_en = 1;
        do_reset();
        check("lit_reset_state", state, 0);
        check("lit_reset_cnt", cycle_cnt, 0);

        // free run
        start = 1;
        tick(1);
        check("lit_run_state", state, 1);
        check("lit_run_cnt0", cycle_cnt, 0);
        tick(4);
        check("lit_run_cnt4", cycle_cnt, 4);

        // load-use: LOAD R2 then ADD R1,R2,R3
        ex_ir = mk(OP_LOAD, 2, 0, 0);
        id_ir = mk(OP_ADD, 1, 2, 3);
        #1;
        check("lit_lu_stall", stall, 1);
        check("lit_lu_bubble", bubble, 1);
        tick(1);
        ex_ir = mk(OP_NOP, 0, 0, 0);
        #1;
        check("lit_lu_stall_cnt", stall_cnt, 1);
        check("lit_lu_cleared", stall, 0);
        ex_ir = mk(OP_LOAD, 2, 0, 0);
        jump = 1;
        #1;
        check("lit_jump_override", stall, 0);
        tick(1);
        jump = 0;

        // LOAD R4: ADDI R5 does not read R4 through r1; STORE r1=4 does; JUMP never stalls
        ex_ir = mk(OP_LOAD, 4, 0, 0);
        id_ir = mk(OP_ADDI, 5, 4, 4);
        #1;
        check("lit_addi_nostall", stall, 0);
        tick(1);
        id_ir = mk(OP_STORE, 4, 0, 0);
        #1;
        check("lit_store_stall", stall, 1);
        tick(1);
        id_ir = mk(OP_JUMP, 4, 4, 4);
        #1;
        check("lit_jump_id_nostall", stall, 0);
        tick(1);
        ex_ir = '0; id_ir = '0;

        // long run saturates the 4-bit instance
        tick(20);
        check("lit_small_sat", s_cycle_cnt, 15);

        // HALT in WB
        wb_ir = mk(OP_HALT, 0, 0, 0);
        tick(1);
        wb_ir = '0;
        check("lit_halted", halted, 1);
        check("lit_halted_state", state, 0);
        start = 0;
        tick(1);
        start = 1;
        tick(1);
        check("lit_halt_to_idle", halted, 0);

        // single-step: three pulses give exactly three exec cycles
        do_reset();
        step_mode = 1;
        start = 1;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            step = 1;
            tick(1);
            step = 0;
            tick(2);
        end
        check("lit_step_cnt", cycle_cnt, 3);
        check("lit_step_paused", state, 0);

        // reset asserted mid-run
        step_mode = 0;
        start = 0;
        tick(1);
        start = 1;
        tick(3);
        reset = 1;
        #1;
        check("lit_midrst_state", state, 0);
        check("lit_midrst_cnt", cycle_cnt, 0);
        tick(1);
        reset = 0;

        // random phase
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 5) == 0) start = ~start;
            if ($urandom_range(0, 3) == 0) step = ~step;
            if ($urandom_range(0, 49) == 0) step_mode = ~step_mode;
            jump = ($urandom_range(0, 4) == 0);
            ex_ir = mk(($urandom_range(0, 1) == 0) ? OP_LOAD : 5'($urandom_range(0, 31)),
                       $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7));
            id_ir = mk(5'($urandom_range(0, 31)),
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            wb_ir = mk(($urandom_range(0, 29) == 0) ? OP_HALT : OP_NOP,
                       $urandom_range(0, 7), 0, 0);
            tick(1);
        end

        reset = 0;
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
